// File: rtl/instruction_fetch_queue_pkg.sv
// Shared constants, state encoding and queue entry layout for the instruction fetch queue.
package instruction_fetch_queue_pkg;

    localparam logic       ENABLE    = 1'b1;
    localparam logic       DISABLE   = 1'b0;
    localparam logic       READ      = 1'b1;
    localparam logic [3:0] FULL_MASK = 4'b1111;

    typedef enum logic [1:0] {
        FQ_IDLE    = 2'd0,
        FQ_WAIT    = 2'd1,
        FQ_DISCARD = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fq_entry_t;

    // PCs are held as word addresses; the low two bits are always zero.
    function automatic logic [31:0] word_to_pc(input logic [29:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Instruction memory read port plus the decode-side valid/ready handshake.
interface instruction_fetch_queue_if;

    logic        memory_interface_enable;
    logic        memory_interface_state;
    logic [31:0] memory_interface_address;
    logic [3:0]  memory_interface_frame_mask;
    logic        memory_interface_ready;
    logic [31:0] memory_interface_data;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_ready;

    modport master (
        output memory_interface_enable, memory_interface_state, memory_interface_address,
               memory_interface_frame_mask, instruction_valid, instruction, instruction_pc,
        input  memory_interface_ready, memory_interface_data, instruction_ready
    );

    modport slave (
        input  memory_interface_enable, memory_interface_state, memory_interface_address,
               memory_interface_frame_mask, instruction_valid, instruction, instruction_pc,
        output memory_interface_ready, memory_interface_data, instruction_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH x 64-bit FIFO with pointer wrap, occupancy count and a flush that empties it in one cycle.
module fetch_queue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [63:0]            wdata,
    output logic [63:0]            rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is not reset; consumers only look at it while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetch stage: owns the fetch PC, issues one read at a time and queues returned words for decode.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    instruction_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_e     state, state_nxt;
    logic [29:0]   fetch_word, fetch_word_nxt;
    logic [29:0]   req_word, req_word_nxt;
    logic          push, pop, full, empty, ready;
    logic [CW-1:0] count;
    fq_entry_t     wr_entry, rd_entry;
    logic [1:0]    unused_pc_bits;

    assign unused_pc_bits = redirect_pc[1:0];
    assign ready          = bus.memory_interface_ready;
    assign pop            = bus.instruction_valid && bus.instruction_ready;
    assign wr_entry       = '{data: bus.memory_interface_data, pc: word_to_pc(fetch_word)};

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FQ_IDLE;
            fetch_word <= RESET_PC[31:2];
            req_word   <= '0;
        end else begin
            state      <= state_nxt;
            fetch_word <= fetch_word_nxt;
            req_word   <= req_word_nxt;
        end
    end

    // req_word keeps the address of the outstanding read, which outlives fetch_word in DISCARD.
    always_comb begin
        state_nxt      = state;
        fetch_word_nxt = redirect_valid ? redirect_pc[31:2] : fetch_word;
        req_word_nxt   = req_word;
        push           = 1'b0;
        case (state)
            FQ_IDLE: begin
                if (!redirect_valid && !full) begin
                    state_nxt    = FQ_WAIT;
                    req_word_nxt = fetch_word;
                end
            end
            FQ_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = ready ? FQ_IDLE : FQ_DISCARD;
                end else if (ready) begin
                    push           = 1'b1;
                    fetch_word_nxt = fetch_word + 30'd1;
                    // Chain the next read only if its response is guaranteed a free slot.
                    if ((count + CW'(1) - CW'(pop)) < CW'(DEPTH)) begin
                        state_nxt    = FQ_WAIT;
                        req_word_nxt = fetch_word + 30'd1;
                    end else begin
                        state_nxt = FQ_IDLE;
                    end
                end
            end
            FQ_DISCARD: begin
                if (ready) begin
                    if (!redirect_valid && !full) begin
                        state_nxt    = FQ_WAIT;
                        req_word_nxt = fetch_word;
                    end else begin
                        state_nxt = FQ_IDLE;
                    end
                end
            end
            default: state_nxt = FQ_IDLE;
        endcase
    end

    assign bus.memory_interface_enable     = (state != FQ_IDLE) ? ENABLE : DISABLE;
    assign bus.memory_interface_state      = READ;
    assign bus.memory_interface_address    = bus.memory_interface_enable ? word_to_pc(req_word) : '0;
    assign bus.memory_interface_frame_mask = bus.memory_interface_enable ? FULL_MASK : '0;
    assign bus.instruction_valid           = !empty;
    assign bus.instruction                 = empty ? '0 : rd_entry.data;
    assign bus.instruction_pc              = empty ? '0 : rd_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized and directed bench for instruction_fetch_queue against a queue-based behavioural model.
module tb_instruction_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        echo;
    logic [31:0] rnd_data;
    int          vectors = 0;
    int          miscompares = 0;

    // Behavioural model: one outstanding read, a "drop it" flag and a queue of delivered words.
    ent_t        mq[$];
    logic        m_out, m_stale;
    logic [31:0] m_pc, m_addr;
    bit          model_ok = 0;

    instruction_fetch_queue_if bus();

    instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.memory_interface_data = echo ? bus.memory_interface_address : rnd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (bus.memory_interface_enable !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (bus.memory_interface_enable !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: enable still low after 20 cycles, required high", name);
        end
    endtask

    always @(posedge clk) begin
        int n0;
        bit done;
        if (!reset) begin
            mq.delete();
            m_pc     = RST_PC;
            m_out    = 1'b0;
            m_stale  = 1'b0;
            m_addr   = '0;
            model_ok = 1;
        end else begin
            n0   = mq.size();
            done = m_out && bus.memory_interface_ready;
            if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (done) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (n0 > 0 && bus.instruction_ready) void'(mq.pop_front());
                if (done) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                        m_out   = (n0 < DEPTH);
                    end else begin
                        mq.push_back('{data: bus.memory_interface_data, pc: m_addr});
                        m_pc  = m_pc + 32'd4;
                        m_out = (mq.size() < DEPTH);
                    end
                    m_addr = m_pc;
                end else if (!m_out && n0 < DEPTH) begin
                    m_out  = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("enable", 32'(bus.memory_interface_enable), 32'(m_out));
            chk("address", bus.memory_interface_address, m_out ? m_addr : 32'h0);
            chk("frame_mask", 32'(bus.memory_interface_frame_mask), m_out ? 32'hF : 32'h0);
            chk("mem_state", 32'(bus.memory_interface_state), 32'h1);
            chk("instr_valid", 32'(bus.instruction_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("instruction", bus.instruction, mq[0].data);
                chk("instruction_pc", bus.instruction_pc, mq[0].pc);
            end else begin
                chk("instruction_idle", bus.instruction, 32'h0);
                chk("instruction_pc_idle", bus.instruction_pc, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] wrap_seq [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        logic [31:0] got[$];
        logic [31:0] old_addr;
        int          ir_pct;

        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        echo = 1'b1; rnd_data = '0;
        bus.memory_interface_ready = 1'b0;
        bus.instruction_ready = 1'b0;
        repeat (2) step();
        chk("rst_enable", 32'(bus.memory_interface_enable), 32'h0);
        chk("rst_state", 32'(bus.memory_interface_state), 32'h1);
        chk("rst_valid", 32'(bus.instruction_valid), 32'h0);

        // Free-running memory from RESET_PC near the top of memory: PC must wrap to 0.
        reset = 1'b1;
        bus.memory_interface_ready = 1'b1;
        bus.instruction_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wrap_addr", bus.memory_interface_address, wrap_seq[k]);
            if (k > 0) chk("wrap_pc", bus.instruction_pc, wrap_seq[k-1]);
        end

        // Redirect to 0 with decode stalled: queue fills with 0x0..0xC and fetch stops.
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        bus.instruction_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        chk("full_enable", 32'(bus.memory_interface_enable), 32'h0);
        chk("full_head_pc", bus.instruction_pc, 32'h0);

        bus.instruction_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            if (bus.instruction_valid) got.push_back(bus.instruction_pc);
            step();
        end
        if (got.size() < 5) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d entries, required 5", got.size());
        end
        for (int i = 0; i < got.size(); i++) chk("drain_pc", got[i], 32'(4 * i));

        // Redirect while a read is outstanding and memory stalls for 3 cycles.
        wait_enable("wait_before_discard");
        old_addr = bus.memory_interface_address;
        bus.memory_interface_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        chk("discard_enable", 32'(bus.memory_interface_enable), 32'h1);
        chk("discard_addr", bus.memory_interface_address, old_addr);
        chk("discard_valid", 32'(bus.instruction_valid), 32'h0);
        repeat (2) step();
        bus.memory_interface_ready = 1'b1;
        step();
        chk("retarget_addr", bus.memory_interface_address, 32'h0000_0100);
        chk("retarget_valid", 32'(bus.instruction_valid), 32'h0);
        step();
        chk("retarget_pc", bus.instruction_pc, 32'h0000_0100);

        // Redirect in the same cycle memory returns data: that word must vanish.
        wait_enable("wait_before_same_cycle");
        echo = 1'b0; rnd_data = 32'hDEAD_BEEF;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
        step();
        redirect_valid = 1'b0; echo = 1'b1;
        chk("same_valid", 32'(bus.instruction_valid), 32'h0);
        chk("same_enable", 32'(bus.memory_interface_enable), 32'h0);
        step();
        chk("same_addr", bus.memory_interface_address, 32'h0000_2000);
        step();
        chk("same_pc", bus.instruction_pc, 32'h0000_2000);
        chk("same_instr", bus.instruction, 32'h0000_2000);

        // Reset with a partly full queue and a read in flight; stale ready stays high.
        bus.instruction_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("midrst_enable", 32'(bus.memory_interface_enable), 32'h0);
        chk("midrst_valid", 32'(bus.instruction_valid), 32'h0);
        chk("midrst_addr", bus.memory_interface_address, 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("midrst_first_addr", bus.memory_interface_address, RST_PC);

        // Random traffic with decode pressure varying by phase.
        echo = 1'b0;
        for (int ph = 0; ph < 4; ph++) begin
            ir_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 100;
            for (int c = 0; c < 800; c++) begin
                reset          = ($urandom_range(0, 249) != 0);
                redirect_valid = ($urandom_range(0, 29) == 0);
                redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
                bus.memory_interface_ready = ($urandom_range(0, 9) < 6);
                bus.instruction_ready      = ($urandom_range(0, 99) < ir_pct);
                rnd_data = $urandom;
                step();
            end
        end

        reset = 1'b1; redirect_valid = 1'b0;
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
